fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage WISC-15 pipeline, directly upstream of the instruction memory. Owns the program counter, drives the address and read enable to instruction memory, and registers the returned word into the IF/ID pipeline register. Handles hazard stalls, taken-branch/jump redirects, and halt detection. The decode stage consumes its IF/ID outputs.

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the WISC-15 five-stage pipeline.
//
// Owns the program counter, presents it to instruction memory, and
// registers the returned word into the IF/ID pipeline register. It also
// handles hazard stalls, taken-branch/jump redirects and HLT detection.
//
// Build option:
//   FETCH_HLT_DETECT_EN  When defined, an HLT opcode freezes the PC and moves
//                        the stage to HALTED. When undefined, HLT is fetched
//                        as an ordinary word and halted is tied low.
//
// Parameters:
//   RESET_PC      PC value loaded on reset.
//   HLT_OPCODE    instr[15:12] value that marks HLT.
//
// Ports:
//   clk            pipeline clock, rising-edge active
//   rst            synchronous active-high reset
//   stall          hazard-unit stall; holds PC, IF/ID and state
//   redirect       taken branch/jump resolved downstream
//   redirect_pc    redirect target word address
//   im_addr        instruction memory address (= PC)
//   im_rd_en       instruction memory read enable
//   im_instr       word returned by instruction memory
//   ifid_instr     registered instruction to decode
//   ifid_pc_plus1  registered PC+1 of that instruction
//   ifid_valid     0 marks a bubble in the IF/ID slot
//   halted         high while the stage is HALTED
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  input  logic [15:0] im_instr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcp1_q, pcp1_d;
  logic        valid_q, valid_d;
  logic        run;
  logic        is_hlt;

`ifdef FETCH_HLT_DETECT_EN
  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;

  assign run    = (state_q == RUN);
  assign is_hlt = (im_instr[15:12] == HLT_OPCODE);
`else
  assign run    = 1'b1;
  assign is_hlt = 1'b0;
`endif

  assign im_addr  = pc_q;
  assign im_rd_en = ~rst & run & ~stall;
  assign halted   = ~run;

  assign ifid_instr    = instr_q;
  assign ifid_pc_plus1 = pcp1_q;
  assign ifid_valid    = valid_q;

  // Next-state: redirect beats stall, so a wrong-path HLT is always squashed.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
`ifdef FETCH_HLT_DETECT_EN
    state_d = state_q;
`endif
    if (redirect) begin
      pc_d    = redirect_pc;
      instr_d = 16'h0000;
      valid_d = 1'b0;
`ifdef FETCH_HLT_DETECT_EN
      state_d = RUN;
`endif
    end else if (stall) begin
      // hold everything
    end else if (run) begin
      instr_d = im_instr;
      pcp1_d  = pc_q + 16'd1;
      valid_d = 1'b1;
      if (is_hlt) begin
        // HLT itself retires downstream; the PC parks on its address.
`ifdef FETCH_HLT_DETECT_EN
        state_d = HALTED;
`endif
      end else begin
        pc_d = pc_q + 16'd1;
      end
    end else begin
      // HALTED: the HLT was captured last edge, feed bubbles from now on.
      instr_d = 16'h0000;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      pcp1_q  <= 16'h0000;
      valid_q <= 1'b0;
`ifdef FETCH_HLT_DETECT_EN
      state_q <= RUN;
`endif
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
`ifdef FETCH_HLT_DETECT_EN
      state_q <= state_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] im_addr, im_instr;
  logic        im_rd_en;
  logic [15:0] ifid_instr, ifid_pc_plus1;
  logic        ifid_valid, halted;

  logic [15:0] mem [0:65535];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: architectural view of the stage.
  logic [15:0] m_pc, m_instr, m_pp1;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  assign im_instr = mem[im_addr];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_addr(im_addr), .im_rd_en(im_rd_en),
    .im_instr(im_instr), .ifid_instr(ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the stage as the rules describe it.
  task automatic model_edge(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
    logic [15:0] word;
    word = mem[m_pc];
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0;
    end else if (rd) begin
      m_pc = rpc; m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (s) begin
      // nothing changes
    end else if (!m_halted) begin
      m_instr = word; m_pp1 = m_pc + 16'd1; m_valid = 1'b1;
`ifdef FETCH_HLT_DETECT_EN
      if (word[15:12] == 4'hF) m_halted = 1'b1;
      else m_pc = m_pc + 16'd1;
`else
      m_pc = m_pc + 16'd1;
`endif
    end else begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end
  endtask

  // Apply inputs for one cycle, check combinational outputs, clock, check registers.
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    check("im_addr", {16'h0, im_addr}, {16'h0, m_pc});
    check("im_rd_en", {31'h0, im_rd_en}, {31'h0, (!r && !m_halted && !s)});
    check("halted", {31'h0, halted}, {31'h0, m_halted});
    @(posedge clk);
    model_edge(r, s, rd, rpc);
    #1;
    check("ifid_instr", {16'h0, ifid_instr}, {16'h0, m_instr});
    check("ifid_pc_plus1", {16'h0, ifid_pc_plus1}, {16'h0, m_pp1});
    check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    m_pc = 16'h0; m_instr = 16'h0; m_pp1 = 16'h0; m_valid = 1'b0; m_halted = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[12] = 1'b0;
      mem[i] = w;
    end
    mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003; mem[3] = 16'hF000;

    // Reset
    cyc(1, 0, 0, 16'h0);
    cyc(1, 0, 0, 16'h0);
    check("rst_pc", {16'h0, im_addr}, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);

    // Straight-line program
    cyc(0, 0, 0, 16'h0);
    check("prog0", {ifid_instr, ifid_pc_plus1}, 32'h1001_0001);
    cyc(0, 0, 0, 16'h0);
    check("prog1", {ifid_instr, ifid_pc_plus1}, 32'h2002_0002);
    cyc(0, 0, 0, 16'h0);
    check("prog2", {ifid_instr, ifid_pc_plus1}, 32'h3003_0003);
    cyc(0, 0, 0, 16'h0);
    check("hlt_capture", {15'h0, ifid_valid, ifid_instr}, 32'h0001_F000);
`ifdef FETCH_HLT_DETECT_EN
    check("hlt_halted", {31'h0, halted}, 32'h1);
    check("hlt_pc", {16'h0, im_addr}, 32'h3);
    check("hlt_rd_en", {31'h0, im_rd_en}, 32'h0);
    cyc(0, 0, 0, 16'h0);
    check("hlt_bubble", {31'h0, ifid_valid}, 32'h0);
    cyc(0, 0, 0, 16'h0);
    // Reset beats redirect while halted
    cyc(1, 0, 1, 16'h0123);
    check("rst_over_halt", {15'h0, halted, im_addr}, 32'h0);
    cyc(0, 0, 0, 16'h0); cyc(0, 0, 0, 16'h0); cyc(0, 0, 0, 16'h0); cyc(0, 0, 0, 16'h0);
    cyc(0, 0, 1, 16'h0010);
    check("redir_unhalt", {15'h0, halted, im_addr}, 32'h0010);
`else
    check("nohlt_halted", {31'h0, halted}, 32'h0);
    check("nohlt_pc", {16'h0, im_addr}, 32'h4);
    cyc(0, 0, 1, 16'h0010);
`endif
    cyc(0, 0, 0, 16'h0);
    check("redir_fetch", {16'h0, ifid_instr}, {16'h0, mem[16'h0010]});

    // Stall at PC=5
    cyc(0, 0, 1, 16'h0005);
    cyc(0, 1, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    check("stall_pc", {16'h0, im_addr}, 32'h5);
    cyc(0, 0, 0, 16'h0);
    check("stall_rel5", {ifid_instr, ifid_pc_plus1}, {mem[5], 16'h0006});
    cyc(0, 0, 0, 16'h0);
    check("stall_rel6", {ifid_instr, ifid_pc_plus1}, {mem[6], 16'h0007});

    // Redirect with concurrent stall
    cyc(0, 1, 1, 16'h0040);
    check("rs_pc", {15'h0, ifid_valid, im_addr}, 32'h0040);
    cyc(0, 0, 0, 16'h0);
    check("rs_fetch", {15'h0, ifid_valid, ifid_instr}, {15'h0, 1'b1, mem[16'h0040]});

    // PC wrap
    cyc(0, 0, 1, 16'hFFFF);
    cyc(0, 0, 0, 16'h0);
    check("wrap_pp1", {16'h0, ifid_pc_plus1}, 32'h0);
    check("wrap_pc", {16'h0, im_addr}, 32'h0);

    // Random traffic with HLTs sprinkled into the low region
    for (int i = 0; i < 24; i++) mem[$urandom_range(4, 255)] = 16'hF000 | 16'($urandom_range(0, 4095));
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), 16'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
